// File: rtl/hit_judge.sv
// rtl/hit_judge.sv - reaction-game judge: target capture, reaction window, BCD score, miss count
// Optional feature macro: HIT_JUDGE_PENALTY_EN (wrong-button misses also decrement the score).
module hit_judge #(
   parameter int WINDOW_CYCLES = 100000000,
   parameter int MAX_MISSES    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freq,
   input  logic [7:0]  LED_num,
   input  logic [7:0]  btn,
   output logic [7:0]  LED_on,
   output logic [15:0] score_bcd,
   output logic [2:0]  misses,
   output logic        hit_pulse,
   output logic        miss_pulse,
   output logic        game_over
);

   typedef enum logic [1:0] {S_IDLE, S_LATCH, S_ARMED, S_OVER} state_t;

   localparam logic [26:0] WIN_LAST   = 27'(WINDOW_CYCLES - 1);
   localparam logic [2:0]  MISS_LIMIT = 3'(MAX_MISSES);

   state_t      state_q, state_d;
   logic [7:0]  sync1_q, sync2_q, edge_q;
   logic [7:0]  press;
   logic [7:0]  target_q, target_d;
   logic [26:0] cnt_q, cnt_d;
   logic [15:0] score_q, score_d;
   logic [2:0]  misses_q, misses_d;
   logic        hit_q, hit_d;
   logic        miss_q, miss_d;
   logic        miss_now;
   logic        num_onehot;

   // BCD +1 with per-digit carry; 9999 holds
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      if (v != 16'h9999) begin
         for (int i = 0; i < 4; i++) begin
            if (carry) begin
               if (v[i*4 +: 4] == 4'd9) begin
                  r[i*4 +: 4] = 4'd0;
               end else begin
                  r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                  carry       = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

`ifdef HIT_JUDGE_PENALTY_EN
   // BCD -1 with per-digit borrow; 0000 holds
   function automatic logic [15:0] bcd_dec(input logic [15:0] v);
      logic [15:0] r;
      logic        borrow;
      r      = v;
      borrow = 1'b1;
      if (v != 16'h0000) begin
         for (int i = 0; i < 4; i++) begin
            if (borrow) begin
               if (v[i*4 +: 4] == 4'd0) begin
                  r[i*4 +: 4] = 4'd9;
               end else begin
                  r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                  borrow      = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction
`endif

   assign press      = sync2_q & ~edge_q;
   assign num_onehot = (LED_num != 8'd0) && ((LED_num & (LED_num - 8'd1)) == 8'd0);

   // Button synchronizer and rising-edge history
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 8'd0;
         sync2_q <= 8'd0;
         edge_q  <= 8'd0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
         edge_q  <= sync2_q;
      end
   end

   // Game state, window counter, score and miss registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         target_q <= 8'd0;
         cnt_q    <= 27'd0;
         score_q  <= 16'h0000;
         misses_q <= 3'd0;
         hit_q    <= 1'b0;
         miss_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
         score_q  <= score_d;
         misses_q <= misses_d;
         hit_q    <= hit_d;
         miss_q   <= miss_d;
      end
   end

   // Next-state: round sequencing and judging; the final miss diverts to OVER
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      score_d  = score_q;
      misses_d = misses_q;
      hit_d    = 1'b0;
      miss_d   = 1'b0;
      miss_now = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (freq) state_d = S_LATCH;
         end
         S_LATCH: begin
            target_d = LED_num;
            if (num_onehot) begin
               state_d = S_ARMED;
               cnt_d   = 27'd0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ARMED: begin
            cnt_d = cnt_q + 27'd1;
            if (freq) begin
               miss_now = 1'b1;
               state_d  = S_LATCH;
            end else if ((press != 8'd0) && (press == target_q)) begin
               hit_d   = 1'b1;
               score_d = bcd_inc(score_q);
               state_d = S_IDLE;
            end else if (press != 8'd0) begin
               miss_now = 1'b1;
               state_d  = S_IDLE;
`ifdef HIT_JUDGE_PENALTY_EN
               score_d  = bcd_dec(score_q);
`endif
            end else if (cnt_q == WIN_LAST) begin
               miss_now = 1'b1;
               state_d  = S_IDLE;
            end
         end
         S_OVER: begin
            state_d = S_OVER;
         end
         default: state_d = S_IDLE;
      endcase
      if (miss_now) begin
         miss_d   = 1'b1;
         misses_d = misses_q + 3'd1;
         if (misses_d == MISS_LIMIT) state_d = S_OVER;
      end
   end

   // Outputs decoded from registered state
   always_comb begin
      LED_on = 8'd0;
      if (state_q == S_ARMED) LED_on = target_q;
      else if (state_q == S_OVER) LED_on = 8'hFF;
   end

   assign score_bcd  = score_q;
   assign misses     = misses_q;
   assign hit_pulse  = hit_q;
   assign miss_pulse = miss_q;
   assign game_over  = (state_q == S_OVER);

endmodule

// File: tb/tb_hit_judge.sv
// tb/tb_hit_judge.sv - directed self-checking bench for hit_judge
module tb_hit_judge;

   logic        clk = 1'b0;
   logic        rst;
   logic        freq;
   logic [7:0]  LED_num;
   logic [7:0]  btn;
   logic [7:0]  LED_on;
   logic [15:0] score_bcd;
   logic [2:0]  misses;
   logic        hit_pulse;
   logic        miss_pulse;
   logic        game_over;

   int errors = 0;
   int checks = 0;
   int n_found;
   int pulses;
   logic [7:0] led_seen;

   hit_judge #(.WINDOW_CYCLES(16), .MAX_MISSES(3)) dut (
      .clk(clk), .rst(rst), .freq(freq), .LED_num(LED_num), .btn(btn),
      .LED_on(LED_on), .score_bcd(score_bcd), .misses(misses),
      .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .game_over(game_over)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One complete hit round; returns in the cycle the hit pulse is visible
   task automatic do_hit(input logic [7:0] t);
      LED_num = t; freq = 1'b1;
      tick();
      freq = 1'b0; btn = t;
      tick();
      btn = 8'd0;
      tick();
      tick();
   endtask

   // Start a round and count cycles from ARMED entry until miss_pulse
   task automatic timeout_round(input logic [7:0] t, output int n);
      LED_num = t; freq = 1'b1;
      tick();
      freq = 1'b0;
      tick();
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (miss_pulse === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_led"},   32'(LED_on),     32'h0);
      chk({tag, "_score"}, 32'(score_bcd),  32'h0);
      chk({tag, "_miss"},  32'(misses),     32'h0);
      chk({tag, "_hitp"},  32'(hit_pulse),  32'h0);
      chk({tag, "_missp"}, 32'(miss_pulse), 32'h0);
      chk({tag, "_over"},  32'(game_over),  32'h0);
   endtask

   initial begin
      rst = 1'b0; freq = 1'b0; LED_num = 8'd0; btn = 8'd0;
      tick();
      tick();
      chk_reset_vals("reset");
      rst = 1'b1;
      tick();

      // Basic hit on LED 2
      LED_num = 8'h04; freq = 1'b1;
      tick();
      freq = 1'b0; btn = 8'h04;
      chk("latch_led", 32'(LED_on), 32'h00);
      tick();
      btn = 8'h00;
      chk("armed_led", 32'(LED_on), 32'h04);
      tick();
      chk("hit_early", 32'(hit_pulse), 32'h0);
      tick();
      chk("hit_pulse", 32'(hit_pulse), 32'h1);
      chk("hit_score", 32'(score_bcd), 32'h0001);
      chk("hit_miss",  32'(misses),    32'h0);
      tick();
      chk("hit_once",  32'(hit_pulse), 32'h0);
      chk("hit_led0",  32'(LED_on),    32'h00);

      // Score to 5, then target 0x10 with 0x30 pressed together
      for (int i = 0; i < 4; i++) do_hit(8'h01);
      chk("score5", 32'(score_bcd), 32'h0005);
      LED_num = 8'h10; freq = 1'b1;
      tick();
      freq = 1'b0; btn = 8'h30;
      tick();
      btn = 8'h00;
      tick();
      tick();
      chk("wrong_missp", 32'(miss_pulse), 32'h1);
      chk("wrong_hitp",  32'(hit_pulse),  32'h0);
      chk("wrong_miss",  32'(misses),     32'h1);
`ifdef HIT_JUDGE_PENALTY_EN
      chk("wrong_score", 32'(score_bcd), 32'h0004);
`else
      chk("wrong_score", 32'(score_bcd), 32'h0005);
`endif

      // Timeout: exactly 16 cycles after ARMED entry
      tick();
      timeout_round(8'h02, n_found);
      chk("timeout_cyc",  32'(n_found), 32'd16);
      chk("timeout_miss", 32'(misses),  32'h2);
      chk("timeout_led",  32'(LED_on),  32'h00);
      chk("timeout_over", 32'(game_over), 32'h0);

      // Void round: zero target, no pulse and no light
      tick();
      LED_num = 8'h00; freq = 1'b1;
      tick();
      freq = 1'b0;
      pulses = 0; led_seen = 8'h00;
      for (int i = 0; i < 24; i++) begin
         tick();
         pulses   += int'(hit_pulse) + int'(miss_pulse);
         led_seen |= LED_on;
      end
      chk("void_pulses", 32'(pulses),   32'd0);
      chk("void_led",    32'(led_seen), 32'h00);
      // Press while idle is ignored, then a normal round still works
      btn = 8'h01;
      for (int i = 0; i < 5; i++) tick();
      btn = 8'h00;
      chk("idle_press", 32'(hit_pulse | miss_pulse), 32'h0);
      tick();
      tick();
      do_hit(8'h80);
      chk("after_void_hit", 32'(hit_pulse), 32'h1);

      // Reset clears mid-game state
      rst = 1'b0;
      #2;
      chk_reset_vals("rst2");
      tick();
      rst = 1'b1;
      tick();

      // Second freq while ARMED preempts as a miss; new target lit two cycles later
      LED_num = 8'h04; freq = 1'b1;
      tick();
      freq = 1'b0;
      tick();
      chk("pre_led1", 32'(LED_on), 32'h04);
      LED_num = 8'h08; freq = 1'b1;
      tick();
      freq = 1'b0;
      chk("pre_missp", 32'(miss_pulse), 32'h1);
      chk("pre_miss",  32'(misses),     32'h1);
      tick();
      chk("pre_led2",  32'(LED_on),     32'h08);
      n_found = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (miss_pulse === 1'b1) begin
            n_found = i;
            break;
         end
      end
      chk("pre_timeout", 32'(n_found), 32'd16);
      chk("pre_miss2",   32'(misses),  32'h2);

      // Third miss ends the game
      tick();
      timeout_round(8'h40, n_found);
      chk("over_cyc",   32'(n_found),   32'd16);
      chk("over_miss",  32'(misses),    32'h3);
      chk("over_flag",  32'(game_over), 32'h1);
      chk("over_led",   32'(LED_on),    32'hFF);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         freq    = (i % 4 == 0);
         LED_num = 8'h01;
         btn     = (i % 2 == 0) ? 8'h01 : 8'h00;
         tick();
         pulses += int'(hit_pulse) + int'(miss_pulse);
      end
      freq = 1'b0; btn = 8'h00;
      chk("over_pulses", 32'(pulses),    32'd0);
      chk("over_miss2",  32'(misses),    32'h3);
      chk("over_led2",   32'(LED_on),    32'hFF);
      chk("over_score",  32'(score_bcd), 32'h0000);
      rst = 1'b0;
      #2;
      chk_reset_vals("rst3");
      tick();
      rst = 1'b1;
      tick();

      // BCD carry and saturation
      for (int i = 0; i < 999; i++) do_hit(8'h02);
      chk("score_0999", 32'(score_bcd), 32'h0999);
      do_hit(8'h02);
      chk("score_1000", 32'(score_bcd), 32'h1000);
      for (int i = 0; i < 8999; i++) do_hit(8'h20);
      chk("score_9999", 32'(score_bcd), 32'h9999);
      do_hit(8'h20);
      chk("sat_hitp",  32'(hit_pulse), 32'h1);
      chk("sat_score", 32'(score_bcd), 32'h9999);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hit_judge.md
# hit_judge

Game-logic stage directly downstream of the randomizer. On each `freq` round pulse it captures the one-hot target LED, lights it for a bounded reaction window, and judges the player's switch/button input against it. Maintains a saturating 4-digit BCD score and a miss count, and ends the game after a configurable number of misses. Its outputs drive the board LEDs and the seven-segment score display.

## Interface
Parameters:
- `WINDOW_CYCLES`, default 100000000: reaction window length in `clk` cycles (1 s at 100 MHz); legal range 2 to 2^27-1.
- `MAX_MISSES`, default 3: misses that end the game; legal range 1 to 7.

Ports:
- `clk`  in  1  system clock, 100 MHz; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `freq`  in  1  one-cycle round-start pulse from the frequency module.
- `LED_num`  in  8  one-hot target from the randomizer; valid from the cycle after `freq`.
- `btn`  in  8  raw, asynchronous player inputs; bit i corresponds to LED i.
- `LED_on`  out  8  target LED lit during the window; 0 otherwise.
- `score_bcd`  out  16  four BCD digits; [15:12] is the thousands digit.
- `misses`  out  3  binary miss count.
- `hit_pulse`  out  1  one-cycle pulse on each judged hit.
- `miss_pulse`  out  1  one-cycle pulse on each judged miss.
- `game_over`  out  1  high once `misses` reaches `MAX_MISSES`.

## Operation
- Input conditioning: `btn` passes through a 2-flop synchronizer, then a rising-edge detector. `press[7:0]` = sync & ~sync_d. Only rising edges count; held inputs never re-trigger.
- States:
  - IDLE: `LED_on` = 0; presses ignored. `freq` moves to LATCH.
  - LATCH: one cycle. Captures `LED_num` into `target`.
    - If `target` is one-hot, go to ARMED and clear the window counter.
    - Otherwise (zero or multi-hot) the round is void: go to IDLE with no pulse.
  - ARMED: `LED_on` = `target`; the window counter increments each cycle. Priority order:
    1. `freq`: counts as a miss (`miss_pulse`), then go to LATCH.
    2. `press` != 0 and `press` == `target`: hit (`hit_pulse`), score +1, go to IDLE.
    3. `press` != 0 and `press` != `target`: any wrong bit, alone or together with the right bit, is a miss; go to IDLE.
    4. Counter == `WINDOW_CYCLES`-1: timeout miss; go to IDLE.
  - OVER: entered instead of IDLE/LATCH whenever the miss that raises `misses` to `MAX_MISSES` is judged. `LED_on` = 8'hFF; `freq` and presses are ignored. Exit only by reset.
- Score arithmetic: BCD increment with per-digit carry (9 to 0 with carry). Saturates at 9999; a hit at 9999 still pulses `hit_pulse` but the score is unchanged.
- `misses` never exceeds `MAX_MISSES`.

## Timing
- Reset values: `LED_on` = 0, `score_bcd` = 16'h0000, `misses` = 0, `hit_pulse` = 0, `miss_pulse` = 0, `game_over` = 0; state IDLE; synchronizer and edge flops 0.
- `freq` at cycle T puts the block in LATCH at T+1 and ARMED at T+2. `LED_on` is valid from T+2.
- `btn` edge to `press`: 2 cycles. `press` to `hit_pulse`/`miss_pulse`: registered, so the pulse appears 1 cycle later. Score and misses update in the same cycle as the pulse.
- Timeout: `miss_pulse` is asserted exactly `WINDOW_CYCLES` cycles after ARMED is entered.
- `game_over` rises in the same cycle as the final `miss_pulse`.
- Reset mid-round clears everything immediately; no pulse is emitted.

## Configuration
- `HIT_JUDGE_PENALTY_EN`:
  - Defined: a wrong-button miss (ARMED rule 3) also decrements the score by 1 in BCD, saturating at 0000. Timeout and `freq`-preempt misses do not decrement.
  - Undefined: misses never change the score.

## Test plan
- Reset, `freq`, `LED_num` = 8'h04, pulse `btn[2]` -> `LED_on` = 8'h04 two cycles after `freq`; `hit_pulse` once; `score_bcd` = 16'h0001; `misses` = 0.
- `WINDOW_CYCLES` = 16, `freq`, no press -> `miss_pulse` exactly 16 cycles after ARMED entry; `misses` = 1; `LED_on` = 0.
- Target 8'h10, `btn` = 8'h30 rising together -> miss; score unchanged without the macro; score decremented (0005 -> 0004) with `HIT_JUDGE_PENALTY_EN`.
- Preload `score_bcd` = 0999 via hits, then one more hit -> `score_bcd` = 16'h1000; at 9999 a further hit -> still 9999 with `hit_pulse` asserted.
- `MAX_MISSES` = 3, three timeouts -> `game_over` rises with the third `miss_pulse`; `LED_on` = 8'hFF; later `freq` and presses cause no change; `rst` = 0 clears to reset values.
- `LED_num` = 8'h00 at capture -> void round: no pulse, state returns to IDLE. A second `freq` during ARMED -> `miss_pulse`, and the new target is lit two cycles later.
